// File: rtl/ats21_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : ats21_pkg                                                     |
// | Purpose : Shared types, field positions and decode for the ATS21 rx.    |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package ats21_pkg;

  localparam int OP_HI     = 31;
  localparam int OP_LO     = 29;
  localparam int CLK_HI    = 28;
  localparam int CLK_LO    = 25;
  localparam int ALM_HI    = 28;
  localparam int ALM_LO    = 24;
  localparam int MODE_HI   = 28;
  localparam int MODE_LO   = 24;
  localparam int FLAG_BIT  = 23;
  localparam int RATE_HI   = 23;
  localparam int RATE_LO   = 22;
  localparam int ACLK_HI   = 19;
  localparam int ACLK_LO   = 16;
  localparam int VAL_HI    = 15;
  localparam int VAL_LO    = 0;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_SET_CLK   = 3'b001,
    OP_BC_EN     = 3'b010,
    OP_SET_MODE  = 3'b011,
    OP_ILLEGAL   = 3'b100,
    OP_SET_ALARM = 3'b101,
    OP_SET_CNTDN = 3'b110,
    OP_AT_EN     = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_DROP    = 2'b01,
    STAT_ILLEGAL = 2'b10,
    STAT_PROTO   = 2'b11
  } stat_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WORD2  = 2'd1,
    COMMIT = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic        client;
    logic [31:0] word;
  } fifo_entry_t;

  typedef struct packed {
    logic        client;
    opcode_e     opcode;
    logic [3:0]  clock_id;
    logic [4:0]  alarm_id;
    logic        flag;
    logic [1:0]  rate;
    logic [15:0] value;
    logic [4:0]  mode;
  } dec_instr_t;

  // Fields not meaningful for an opcode stay zero.
  function automatic dec_instr_t decode(input fifo_entry_t e);
    dec_instr_t d;
    d        = '0;
    d.client = e.client;
    d.opcode = opcode_e'(e.word[OP_HI:OP_LO]);
    case (d.opcode)
      OP_SET_CLK: begin
        d.clock_id = e.word[CLK_HI:CLK_LO];
        d.rate     = e.word[RATE_HI:RATE_LO];
      end
      OP_BC_EN: begin
        d.clock_id = e.word[CLK_HI:CLK_LO];
        d.flag     = e.word[FLAG_BIT];
      end
      OP_SET_MODE: d.mode = e.word[MODE_HI:MODE_LO];
      OP_SET_ALARM: begin
        d.alarm_id = e.word[ALM_HI:ALM_LO];
        d.clock_id = e.word[ACLK_HI:ACLK_LO];
        d.flag     = e.word[FLAG_BIT];
        d.value    = e.word[VAL_HI:VAL_LO];
      end
      OP_SET_CNTDN: begin
        d.alarm_id = e.word[ALM_HI:ALM_LO];
        d.clock_id = e.word[ACLK_HI:ACLK_LO];
        d.value    = e.word[VAL_HI:VAL_LO];
      end
      OP_AT_EN: begin
        d.alarm_id = e.word[ALM_HI:ALM_LO];
        d.flag     = e.word[FLAG_BIT];
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ats21_dual_push_fifo.sv
// ---------------------------------------------------------------------------
// | Module  : ats21_dual_push_fifo                                          |
// | Purpose : Show-ahead FIFO with two push ports (port 0 first) and a pop.  |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module ats21_dual_push_fifo
  import ats21_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push0,
  input  fifo_entry_t i_din0,
  input  logic        i_push1,
  input  fifo_entry_t i_din1,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_valid,
  output logic [AW:0] o_count
);

  fifo_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_wptr1;
  logic          w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  // Port 1 lands behind port 0 when both push in the same cycle.
  assign w_wptr1 = r_wptr + AW'(i_push0);

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wptr]  <= i_din0;
    if (i_push1) r_mem[w_wptr1] <= i_din1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_push0) + AW'(i_push1);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + (AW+1)'(i_push0) + (AW+1)'(i_push1) - (AW+1)'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ats21_instr_rx.sv
// ---------------------------------------------------------------------------
// | Module  : ats21_instr_rx                                                |
// | Purpose : Two-beat client instruction capture, decode and queueing.     |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module ats21_instr_rx
  import ats21_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic        dec_client,
  output logic [2:0]  dec_opcode,
  output logic [3:0]  dec_clock_id,
  output logic [4:0]  dec_alarm_id,
  output logic        dec_flag,
  output logic [1:0]  dec_rate,
  output logic [15:0] dec_value,
  output logic [4:0]  dec_mode
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_WORD2  = WORD2;
  localparam logic [1:0] S_COMMIT = COMMIT;

  logic [1:0]  r_state;
  logic [1:0]  r_stat;
  logic [15:0] r_hi_a, r_hi_b, r_lo_a, r_lo_b;

  logic [2:0]  w_op_a, w_op_b;
  logic        w_a_present, w_b_present;
  logic        w_commit, w_illegal, w_proto, w_drop;
  logic        w_push0, w_push1;
  fifo_entry_t w_ent_a, w_ent_b, w_din0, w_head;
  logic        w_head_valid;
  logic [AW:0] w_count, w_free;
  dec_instr_t  w_dec;

  assign w_op_a      = r_hi_a[OP_HI-16:OP_LO-16];
  assign w_op_b      = r_hi_b[OP_HI-16:OP_LO-16];
  assign w_a_present = (w_op_a != OP_NOP) && (w_op_a != OP_ILLEGAL);
  assign w_b_present = (w_op_b != OP_NOP) && (w_op_b != OP_ILLEGAL);
  assign w_commit    = (r_state == S_COMMIT);

  assign w_ent_a = '{client: 1'b0, word: {r_hi_a, r_lo_a}};
  assign w_ent_b = '{client: 1'b1, word: {r_hi_b, r_lo_b}};

  // A lone B entry uses port 0 so entries stay contiguous in order.
  assign w_push0 = w_commit & (w_a_present | w_b_present);
  assign w_push1 = w_commit & w_a_present & w_b_present;
  assign w_din0  = w_a_present ? w_ent_a : w_ent_b;

  // Free space counts a pop happening this cycle.
  assign w_free = (AW+1)'(DEPTH) - w_count + (AW+1)'(dec_valid & dec_ready);
  assign ready  = ~reset & (r_state == S_IDLE) & (w_free >= (AW+1)'(2));

  assign w_illegal = w_commit & ((w_op_a == OP_ILLEGAL) | (w_op_b == OP_ILLEGAL));
  assign w_proto   = (r_state == S_WORD2) & req;
  assign w_drop    = req & ~ready & ((r_state == S_IDLE) | w_commit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_stat  <= STAT_OK;
      r_hi_a  <= '0;
      r_hi_b  <= '0;
      r_lo_a  <= '0;
      r_lo_b  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req && ready) begin
            r_hi_a  <= ctrlA;
            r_hi_b  <= ctrlB;
            r_state <= S_WORD2;
          end
        end
        S_WORD2: begin
          r_lo_a  <= ctrlA;
          r_lo_b  <= ctrlB;
          r_state <= S_COMMIT;
        end
        S_COMMIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase

      if (w_proto)        r_stat <= STAT_PROTO;
      else if (w_illegal) r_stat <= STAT_ILLEGAL;
      else if (w_drop)    r_stat <= STAT_DROP;
      else                r_stat <= STAT_OK;
    end
  end

  assign stat = r_stat;

  ats21_dual_push_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push0 (w_push0),
    .i_din0  (w_din0),
    .i_push1 (w_push1),
    .i_din1  (w_ent_b),
    .i_pop   (dec_valid & dec_ready),
    .o_head  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

  always_comb begin
    w_dec = '0;
    if (w_head_valid) w_dec = decode(w_head);
  end

  assign dec_valid    = w_head_valid;
  assign dec_client   = w_dec.client;
  assign dec_opcode   = w_dec.opcode;
  assign dec_clock_id = w_dec.clock_id;
  assign dec_alarm_id = w_dec.alarm_id;
  assign dec_flag     = w_dec.flag;
  assign dec_rate     = w_dec.rate;
  assign dec_value    = w_dec.value;
  assign dec_mode     = w_dec.mode;

endmodule

`default_nettype wire

// File: tb/tb_ats21_instr_rx.sv
// ---------------------------------------------------------------------------
// | Module  : tb_ats21_instr_rx                                             |
// | Purpose : Directed plus random stimulus against a transaction model.    |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ats21_instr_rx;

  localparam int DEPTH = 4;

  logic        clk, reset, req, dec_ready;
  logic [15:0] ctrlA, ctrlB;
  logic        ready, dec_valid, dec_client, dec_flag;
  logic [1:0]  stat, dec_rate;
  logic [2:0]  dec_opcode;
  logic [3:0]  dec_clock_id;
  logic [4:0]  dec_alarm_id, dec_mode;
  logic [15:0] dec_value;

  ats21_instr_rx #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .ctrlA        (ctrlA),
    .ctrlB        (ctrlB),
    .ready        (ready),
    .stat         (stat),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_client   (dec_client),
    .dec_opcode   (dec_opcode),
    .dec_clock_id (dec_clock_id),
    .dec_alarm_id (dec_alarm_id),
    .dec_flag     (dec_flag),
    .dec_rate     (dec_rate),
    .dec_value    (dec_value),
    .dec_mode     (dec_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: queue of {client, word}; an accepted req at cycle acc occupies
  // acc+1 (second beat) and acc+2 (commit, entries written at its end).
  logic [32:0] mq[$];
  int          cyc;
  int          acc;
  logic [15:0] m_hi_a, m_hi_b, m_lo_a, m_lo_b;
  logic [1:0]  m_stat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [36:0] exp_fields(input logic [32:0] e);
    logic [31:0] w;
    int          op;
    logic [3:0]  cid;
    logic [4:0]  aid, md;
    logic        flg;
    logic [1:0]  rt;
    logic [15:0] val;
    w   = e[31:0];
    op  = int'(w >> 29);
    cid = (op == 1 || op == 2) ? 4'((w >> 25) & 32'hF) :
          (op == 5 || op == 6) ? 4'((w >> 16) & 32'hF) : 4'd0;
    aid = (op >= 5) ? 5'((w >> 24) & 32'h1F) : 5'd0;
    flg = (op == 2 || op == 5 || op == 7) ? 1'((w >> 23) & 32'h1) : 1'b0;
    rt  = (op == 1) ? 2'((w >> 22) & 32'h3) : 2'd0;
    val = (op == 5 || op == 6) ? 16'(w & 32'hFFFF) : 16'd0;
    md  = (op == 3) ? 5'((w >> 24) & 32'h1F) : 5'd0;
    return {e[32], 3'(op), cid, aid, flg, rt, val, md};
  endfunction

  function automatic logic [36:0] dut_fields();
    return {dec_client, dec_opcode, dec_clock_id, dec_alarm_id, dec_flag,
            dec_rate, dec_value, dec_mode};
  endfunction

  task automatic model_clear();
    mq.delete();
    acc    = -100;
    m_stat = 2'b00;
  endtask

  // Called at a falling edge; drives one cycle and checks it against the model.
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic dr);
    bit in_w2, in_cm, pop, exp_rdy, proto, drop, take, ill;
    int op_a, op_b;
    req = r; ctrlA = a; ctrlB = b; dec_ready = dr;
    #1;
    in_w2   = (cyc == acc + 1);
    in_cm   = (cyc == acc + 2);
    pop     = (mq.size() > 0) && dr;
    exp_rdy = !in_w2 && !in_cm && ((DEPTH - mq.size() + int'(pop)) >= 2);
    check("ready", 64'(ready), 64'(exp_rdy));
    check("stat", 64'(stat), 64'(m_stat));
    check("dec_valid", 64'(dec_valid), 64'(mq.size() > 0));
    check("dec_fields", 64'(dut_fields()), (mq.size() > 0) ? 64'(exp_fields(mq[0])) : 64'd0);
    proto = in_w2 && r;
    drop  = r && !exp_rdy && !in_w2;
    take  = r && exp_rdy;
    op_a  = int'(m_hi_a >> 13);
    op_b  = int'(m_hi_b >> 13);
    ill   = in_cm && (op_a == 4 || op_b == 4);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (in_cm) begin
      if (op_a != 0 && op_a != 4) mq.push_back({1'b0, m_hi_a, m_lo_a});
      if (op_b != 0 && op_b != 4) mq.push_back({1'b1, m_hi_b, m_lo_b});
    end
    if (in_w2) begin m_lo_a = a; m_lo_b = b; end
    if (take) begin acc = cyc; m_hi_a = a; m_hi_b = b; end
    m_stat = proto ? 2'b11 : ill ? 2'b10 : drop ? 2'b01 : 2'b00;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000, 1'b1);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; ctrlA = '0; ctrlB = '0; dec_ready = 1'b0;
    cyc = 0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_stat", 64'(stat), 64'd0);
    check("rst_valid", 64'(dec_valid), 64'd0);
    check("rst_fields", 64'(dut_fields()), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Set clock, both clients; req sampled at edge T, head valid after edge T+2.
    step(1'b1, 16'h2000, 16'h2240, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("setclk_a_client", 64'(dec_client), 64'd0);
    check("setclk_a_op", 64'(dec_opcode), 64'd1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("setclk_b_client", 64'(dec_client), 64'd1);
    check("setclk_b_clk", 64'(dec_clock_id), 64'd1);
    check("setclk_b_rate", 64'(dec_rate), 64'd1);
    idle(2);

    // Set alarm from A only.
    step(1'b1, 16'hA000, 16'h0000, 1'b1);
    step(1'b0, 16'h0190, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("alarm_op", 64'(dec_opcode), 64'd5);
    check("alarm_value", 64'(dec_value), 64'h0190);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("alarm_single", 64'(dec_valid), 64'd0);

    // Backpressure: fill the FIFO, then a request must be dropped.
    step(1'b1, 16'h2000, 16'h2240, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 16'hE180, 16'hA000, 1'b0);
    step(1'b0, 16'h0000, 16'h0190, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("bp_full_ready", 64'(ready), 64'd0);
    step(1'b1, 16'h2000, 16'h0000, 1'b0);
    check("bp_drop_stat", 64'(stat), 64'd1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("bp_ready_after_pops", 64'(ready), 64'd1);
    idle(3);

    // Illegal opcode on A; only B is queued.
    step(1'b1, 16'h8000, 16'hE180, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("illegal_stat", 64'(stat), 64'd2);
    check("illegal_b_op", 64'(dec_opcode), 64'd7);
    check("illegal_b_alarm", 64'(dec_alarm_id), 64'd1);
    check("illegal_b_flag", 64'(dec_flag), 64'd1);
    idle(2);

    // Protocol error: req held across both beats.
    step(1'b1, 16'h2000, 16'h0000, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    check("proto_stat", 64'(stat), 64'd3);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check("proto_enqueued", 64'(dec_valid), 64'd1);
    idle(3);

    // Reset while in the second beat with two entries queued.
    step(1'b1, 16'h2000, 16'h2240, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 16'hA000, 16'h0000, 1'b0);
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", 64'(dec_valid), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    check("rst_release_ready", 64'(ready), 64'd1);
    #4;
    @(negedge clk);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      step($urandom_range(0, 99) < 45, ra, rb, $urandom_range(0, 3) != 0);
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ats21_instr_rx.md
Name: ats21_instr_rx

Overview:
- Receive end of the ATS21 client instruction interface.
- Captures the two-beat, 16-bit-per-beat instructions from clients A and B on `ctrlA`/`ctrlB`.
- Decodes each 32-bit word into opcode and fields, and queues the results in a small FIFO.
- Presents decoded instructions one per cycle, over a valid/ready handshake, to the ATS21 clock/alarm execution logic.

Parameters:
- DEPTH, 4: decoded-instruction FIFO entries; legal values are powers of two, minimum 2.
- AW, $clog2(DEPTH): FIFO pointer width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  client request strobe; the first beat is present in the same cycle
- ctrlA  in  16  client A word: [31:16] in the req cycle, [15:0] in the next cycle
- ctrlB  in  16  client B word, same timing as ctrlA
- ready  out  1  receiver can accept a new request this cycle
- stat  out  2  one-cycle status pulse: 00 ok, 01 dropped, 10 illegal opcode, 11 protocol error
- dec_valid  out  1  decoded instruction available
- dec_ready  in  1  consumer accepts the head entry
- dec_client  out  1  0 = A, 1 = B
- dec_opcode  out  3  instruction [31:29]
- dec_clock_id  out  4  [28:25] for opcodes 001/010; [19:16] for opcodes 101/110; 0 otherwise
- dec_alarm_id  out  5  [28:24] for opcodes 101/110/111; 0 otherwise
- dec_flag  out  1  bit [23]: enable for 010/111, repeat for 101
- dec_rate  out  2  [23:22] for opcode 001
- dec_value  out  16  [15:0]: alarm time (101) or interval (110)
- dec_mode  out  5  {active[28], AT_perm[27:26], BC_perm[25:24]} for opcode 011

Behaviour:
- Reset is asynchronous and active-high; clock is `clk`, reset is `reset`.
- Reset values: FSM IDLE, FIFO empty, ready=0 during reset and 1 in the first cycle after, stat=00, dec_valid=0, all dec_* fields 0.
- FSM states and transitions:
  - IDLE: req=1 and ready=1 → latch ctrlA/ctrlB as upper halves, go to WORD2.
  - IDLE: req=1 and ready=0 → stat=01 next cycle, stay in IDLE.
  - WORD2: latch lower halves unconditionally and go to COMMIT.
  - WORD2: if req=1, flag a protocol error (stat=11) and ignore that req; the instruction still completes.
  - COMMIT: write up to two entries into the FIFO, return to IDLE. req in COMMIT is treated as in IDLE, but ready=0 there, so it is dropped.
- Client presence: a client whose upper-half opcode is 000 (Nop) produces no entry.
- Illegal opcode 100 is not enqueued and sets stat=10. If both clients are illegal, stat=10 once.
- Write ordering: when both clients are present, A is written before B in the same cycle (dual write, pointer advances by 2).
- ready = (state==IDLE) and (free entries ≥ 2). The free-entry count includes a pop occurring in the same cycle.
- FIFO is show-ahead: dec_* reflect the head entry whenever dec_valid=1. A pop occurs when dec_valid & dec_ready.
- Latency: req at cycle T → dec_valid at T+2 for the first entry, provided the FIFO was empty. The B entry becomes head at T+3 if the A entry is popped at T+2.
- Push and pop in the same cycle are both honoured; the count stays consistent; pointers wrap modulo DEPTH.
- Decode is combinational from the 32-bit word. Stored FIFO entries are {client, 32-bit word}; fields are decoded at the head.
- stat priority within a cycle: 11 > 10 > 01 > 00. Every stat value is a single-cycle pulse.
- Reset asserted mid-instruction discards the partial capture and all queued entries.

Decomposition:
- Package ats21_pkg:
  - opcode enum: NOP=000, SET_CLK=001, BC_EN=010, SET_MODE=011, ILLEGAL=100, SET_ALARM=101, SET_CNTDN=110, AT_EN=111
  - stat_e codes
  - rx_state_e {IDLE, WORD2, COMMIT}
  - decoded-instruction struct
  - field-position localparams
- Sub-module ats21_dual_push_fifo: DEPTH entries, 2 push ports, 1 pop port, show-ahead.

Test Plan:
- **Set clock, both clients:** A=0x2000_0000 (SET_CLK clk0 rate00) and B=0x2240_0000 (clk1 rate01) → T+2: client0, op001, clk0, rate0. T+3: client1, op001, clk1, rate1. stat=00.
- **Set alarm:** A=0xA000_0190 (alarm0 clk0 time 400), B=Nop → single entry: op101, alarm_id0, clock_id0, flag0, value 0x0190. No B entry.
- **Backpressure:** dec_ready=0 with two dual-client instructions queued (FIFO full at DEPTH=4) → ready=0. Third req → stat=01, nothing written. After two pops, ready=1.
- **Illegal opcode:** A=0x8000_0000, B=0xE180_0000 → stat=10. Only the B entry is enqueued: op111, alarm_id1, flag1.
- **Protocol error:** req held high two cycles → stat=11. First instruction is still enqueued; state returns to IDLE after COMMIT.
- **Reset mid-operation:** reset asserted in WORD2 with 2 entries queued → dec_valid=0 immediately (asynchronous). After release, ready=1 and the FIFO is empty.
